// File: rtl/dac_dual_tx.sv
// Dual-channel serial DAC transmitter for DAC121S101-class converters.
// Two 16-bit frames {2'b00, pd_mode, sample} are shifted out MSB first
// on shared SCLK/SYNC. SCLK is clk divided by 2*CLK_DIV.
// Data lines only move at sync fall or on SCLK rising edges.
//
// state | meaning
// IDLE  | ready for a sample pair, all DAC lines at idle values
// SHIFT | sync low, 32 SCLK half-periods, one bit per SCLK period
// GAP   | sync high for CLK_DIV cycles before returning to IDLE
module dac_dual_tx #(
  parameter int CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [11:0] ch_a,
  input  logic [11:0] ch_b,
  input  logic [1:0]  pd_mode,
  output logic        dac_sync_n,
  output logic        dac_sclk,
  output logic        dac_sdata_a,
  output logic        dac_sdata_b,
  output logic        frame_done
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t      state;
  logic [DW-1:0] div_cnt;
  logic [4:0]  half_cnt;
  // Bit 15 of each frame word is always zero and is driven directly at
  // accept, so the shift registers hold only the remaining bits 14:0.
  logic [14:0] sh_a;
  logic [14:0] sh_b;
  logic        div_wrap;

  assign div_wrap = (div_cnt == DIV_LAST);

  // Frame sequencer: accept, SCLK generation, shifting and inter-frame gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      half_cnt    <= '0;
      sh_a        <= '0;
      sh_b        <= '0;
      s_ready     <= 1'b0;
      dac_sync_n  <= 1'b1;
      dac_sclk    <= 1'b1;
      dac_sdata_a <= 1'b0;
      dac_sdata_b <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            state       <= SHIFT;
            s_ready     <= 1'b0;
            div_cnt     <= '0;
            half_cnt    <= '0;
            sh_a        <= {1'b0, pd_mode, ch_a};
            sh_b        <= {1'b0, pd_mode, ch_b};
            dac_sync_n  <= 1'b0;
            dac_sclk    <= 1'b1;
            dac_sdata_a <= 1'b0;
            dac_sdata_b <= 1'b0;
          end
        end
        SHIFT: begin
          if (div_wrap) begin
            div_cnt  <= '0;
            half_cnt <= half_cnt + 5'd1;
            if (!half_cnt[0]) begin
              dac_sclk <= 1'b0;
            end else if (half_cnt != 5'd31) begin
              dac_sclk    <= 1'b1;
              dac_sdata_a <= sh_a[14];
              dac_sdata_b <= sh_b[14];
              sh_a        <= {sh_a[13:0], 1'b0};
              sh_b        <= {sh_b[13:0], 1'b0};
            end else begin
              dac_sclk    <= 1'b1;
              dac_sync_n  <= 1'b1;
              dac_sdata_a <= 1'b0;
              dac_sdata_b <= 1'b0;
              state       <= GAP;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (div_wrap) begin
            div_cnt    <= '0;
            state      <= IDLE;
            s_ready    <= 1'b1;
            frame_done <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_dual_tx.sv
// Scoreboard bench for dac_dual_tx: one default build (CLK_DIV=13) and one
// CLK_DIV=2 build. Stimulus pushes expected frame words; a monitor
// reassembles bits on SCLK falling edges and checks timing at frame_done.
module tb_dac_dual_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  s_valid;
  logic [1:0]  s_ready;
  logic [11:0] ch_a;
  logic [11:0] ch_b;
  logic [1:0]  pd_mode;
  logic [1:0]  sync_n;
  logic [1:0]  sclk;
  logic [1:0]  sda;
  logic [1:0]  sdb;
  logic [1:0]  done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ndone = 0;

  typedef struct {
    int          which;
    logic [15:0] a;
    logic [15:0] b;
    bit          gap;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_dual_tx #(.CLK_DIV(13)) u_dut0 (
    .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .ch_a(ch_a), .ch_b(ch_b), .pd_mode(pd_mode),
    .dac_sync_n(sync_n[0]), .dac_sclk(sclk[0]),
    .dac_sdata_a(sda[0]), .dac_sdata_b(sdb[0]), .frame_done(done[0])
  );

  dac_dual_tx #(.CLK_DIV(2)) u_dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .ch_a(ch_a), .ch_b(ch_b), .pd_mode(pd_mode),
    .dac_sync_n(sync_n[1]), .dac_sclk(sclk[1]),
    .dac_sdata_a(sda[1]), .dac_sdata_b(sdb[1]), .frame_done(done[1])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: per DUT, track sync/sclk edges, collect bits, check at frame_done.
  logic [1:0]  ps = 2'b11, pk = 2'b11, pa = 2'b00, pb = 2'b00, act = 2'b00;
  logic [15:0] ba[2];
  logic [15:0] bb[2];
  int t0[2], tr[2], tl[2], nb[2];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int d;
        d = (i == 0) ? 13 : 2;
        if (rst) begin
          act[i] = 1'b0;
        end else begin
          if (sda[i] !== pa[i] || sdb[i] !== pb[i])
            chk("data_change_sclk_high", {31'd0, sclk[i]}, 32'd1);
          if (ps[i] && !sync_n[i]) begin
            act[i] = 1'b1;
            t0[i] = cyc;
            nb[i] = 0;
            ba[i] = '0;
            bb[i] = '0;
            if (q.size() > 0 && q[0].gap && q[0].which == i)
              chk("sync_high_gap", cyc - tr[i], d + 1);
          end
          if (act[i] && pk[i] && !sclk[i]) begin
            ba[i] = {ba[i][14:0], sda[i]};
            bb[i] = {bb[i][14:0], sdb[i]};
            nb[i]++;
          end
          if (!ps[i] && sync_n[i]) begin
            tr[i] = cyc;
            tl[i] = cyc - t0[i];
          end
          if (done[i]) begin
            ndone++;
            if (!act[i] || q.size() == 0) begin
              chk("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
              e = q.pop_front();
              chk("frame_dut", i, e.which);
              chk("bits_a", ba[i], e.a);
              chk("bits_b", bb[i], e.b);
              chk("sclk_falls", nb[i], 16);
              chk("sync_low_cycles", tl[i], 32 * d);
              chk("done_latency", cyc - t0[i], 33 * d);
              chk("ready_at_done", {31'd0, s_ready[i]}, 32'd1);
            end
            act[i] = 1'b0;
          end
        end
        ps[i] = sync_n[i];
        pk[i] = sclk[i];
        pa[i] = sda[i];
        pb[i] = sdb[i];
      end
    end
  end

  task automatic send(input int which, input logic [11:0] a, input logic [11:0] b,
                      input logic [1:0] pd, input logic [15:0] wa, input logic [15:0] wb,
                      input bit gap, input bit push, input bit hold);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    ch_a = a;
    ch_b = b;
    pd_mode = pd;
    s_valid[which] = 1'b1;
    while (!s_ready[which] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("send_timeout", 32'd1, 32'd0);
    if (push) begin
      e.which = which;
      e.a = wa;
      e.b = wb;
      e.gap = gap;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) s_valid[which] = 1'b0;
  endtask

  task automatic wait_idle(input int which);
    int n;
    n = 0;
    while (!s_ready[which] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_valid = 2'b00;
    ch_a = '0;
    ch_b = '0;
    pd_mode = '0;
    #23;
    chk("rst_ready", {30'd0, s_ready}, 32'd0);
    chk("rst_sync_n", {30'd0, sync_n}, 32'd3);
    chk("rst_sclk", {30'd0, sclk}, 32'd3);
    chk("rst_sdata", {28'd0, sda, sdb}, 32'd0);
    chk("rst_done", {30'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {30'd0, s_ready}, 32'd3);

    // Basic frame.
    send(0, 12'hA5C, 12'h3F0, 2'b00, 16'h0A5C, 16'h03F0, 0, 1, 0);
    wait_idle(0);

    // Power-down bits, with inputs changed mid-frame.
    send(0, 12'hFFF, 12'h000, 2'b11, 16'h3FFF, 16'h3000, 0, 1, 0);
    @(negedge clk);
    ch_a = 12'h000;
    ch_b = 12'hFFF;
    pd_mode = 2'b00;
    wait_idle(0);

    // Back-to-back frames with s_valid held high.
    send(0, 12'h100, 12'h200, 2'b01, 16'h1100, 16'h1200, 0, 1, 1);
    send(0, 12'h101, 12'h201, 2'b01, 16'h1101, 16'h1201, 1, 1, 1);
    send(0, 12'h102, 12'h202, 2'b01, 16'h1102, 16'h1202, 1, 1, 0);
    wait_idle(0);

    // s_valid pulse while busy is ignored.
    send(0, 12'h7FF, 12'h001, 2'b00, 16'h07FF, 16'h0001, 0, 1, 0);
    repeat (99) @(posedge clk);
    #1;
    s_valid[0] = 1'b1;
    chk("busy_ready_low", {31'd0, s_ready[0]}, 32'd0);
    @(posedge clk);
    #1;
    s_valid[0] = 1'b0;
    chk("busy_ready_low_after", {31'd0, s_ready[0]}, 32'd0);
    wait_idle(0);
    repeat (50) @(negedge clk);
    chk("no_extra_frame_sync", {31'd0, sync_n[0]}, 32'd1);
    chk("no_extra_frame_ready", {31'd0, s_ready[0]}, 32'd1);

    // Asynchronous reset in the middle of bit 7.
    send(0, 12'h123, 12'h456, 2'b00, 16'h0123, 16'h0456, 0, 0, 0);
    repeat (221) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_sync_n", {31'd0, sync_n[0]}, 32'd1);
    chk("abort_sclk", {31'd0, sclk[0]}, 32'd1);
    chk("abort_sdata", {30'd0, sda[0], sdb[0]}, 32'd0);
    chk("abort_ready", {31'd0, s_ready[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_abort", {31'd0, s_ready[0]}, 32'd1);
    send(0, 12'h555, 12'hAAA, 2'b10, 16'h2555, 16'h2AAA, 0, 1, 0);
    wait_idle(0);

    // Minimum divider build.
    send(1, 12'h001, 12'h800, 2'b00, 16'h0001, 16'h0800, 0, 1, 0);
    wait_idle(1);

    repeat (20) @(negedge clk);
    chk("frame_done_count", ndone, 8);
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
